// File: rtl/pattern_matcher.sv
// Compares each received frame byte against a per-offset pattern entry read from an external memory.
// At the end of each frame it emits one pass/fail strobe and keeps a running count of matched frames.
module pattern_matcher #(
    parameter int ADDR_WIDTH  = 11,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [7:0]             s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [29:0]            mem_data,
    output logic                   match_valid,
    output logic                   match,
    output logic [COUNT_WIDTH-1:0] match_count
);

    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_PASS   = 2'd1;
    localparam logic [1:0] ST_FAIL   = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] OFFSET_MAX = '1;

    logic [ADDR_WIDTH-1:0]  offset_q, offset_d;
    logic                   frame_en_q, frame_en_d;

    logic                   s1_valid_q, s1_valid_d;
    logic [7:0]             s1_data_q, s1_data_d;
    logic                   s1_last_q, s1_last_d;
    logic                   s1_en_q, s1_en_d;
    logic                   s1_at_max_q, s1_at_max_d;

    logic [1:0]             state_q, state_d;
    logic                   match_valid_q, match_valid_d;
    logic                   match_q, match_d;
    logic [COUNT_WIDTH-1:0] match_count_q, match_count_d;

    logic                   beat_en;
    logic [7:0]             entry_value;
    logic [7:0]             entry_mask;
    logic                   entry_end;
    logic                   byte_pass;
    logic [1:0]             next_state;
    logic                   unused_mem_bits;

    assign entry_value     = mem_data[7:0];
    assign entry_mask      = mem_data[15:8];
    assign entry_end       = mem_data[16];
    assign unused_mem_bits = ^mem_data[29:17];

    assign mem_addr    = offset_q;
    assign match_valid = match_valid_q;
    assign match       = match_q;
    assign match_count = match_count_q;

    // The enable sampled on the first beat of a frame governs the whole frame.
    assign beat_en = (offset_q == '0) ? enable : frame_en_q;

    always_comb begin
        offset_d   = offset_q;
        frame_en_d = frame_en_q;
        if (s_axis_tvalid) begin
            frame_en_d = beat_en;
            if (s_axis_tlast) begin
                offset_d = '0;
            end else if (offset_q != OFFSET_MAX) begin
                offset_d = offset_q + ADDR_WIDTH'(1);
            end
        end
    end

    // Stage 1 delays the byte by one cycle so it lines up with the memory read data.
    always_comb begin
        s1_valid_d  = s_axis_tvalid;
        s1_data_d   = s1_data_q;
        s1_last_d   = s1_last_q;
        s1_en_d     = s1_en_q;
        s1_at_max_d = s1_at_max_q;
        if (s_axis_tvalid) begin
            s1_data_d   = s_axis_tdata;
            s1_last_d   = s_axis_tlast;
            s1_en_d     = beat_en;
            s1_at_max_d = (offset_q == OFFSET_MAX);
        end
    end

    assign byte_pass = ((s1_data_q ^ entry_value) & entry_mask) == 8'h00;

    always_comb begin
        next_state = state_q;
        if (s1_valid_q && s1_en_q && (state_q == ST_ACTIVE)) begin
            if (!byte_pass) begin
                next_state = ST_FAIL;
            end else if (entry_end) begin
                next_state = ST_PASS;
            end else if (s1_at_max_q) begin
                next_state = ST_FAIL;
            end
        end
    end

    // The verdict includes the transition caused by the last byte itself.
    always_comb begin
        state_d       = next_state;
        match_valid_d = 1'b0;
        match_d       = 1'b0;
        match_count_d = match_count_q;
        if (s1_valid_q && s1_last_q) begin
            state_d       = ST_ACTIVE;
            match_valid_d = 1'b1;
            match_d       = (next_state == ST_PASS);
            if (next_state == ST_PASS) begin
                match_count_d = match_count_q + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset_q      <= '0;
            frame_en_q    <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_data_q     <= 8'h00;
            s1_last_q     <= 1'b0;
            s1_en_q       <= 1'b0;
            s1_at_max_q   <= 1'b0;
            state_q       <= ST_ACTIVE;
            match_valid_q <= 1'b0;
            match_q       <= 1'b0;
            match_count_q <= '0;
        end else begin
            offset_q      <= offset_d;
            frame_en_q    <= frame_en_d;
            s1_valid_q    <= s1_valid_d;
            s1_data_q     <= s1_data_d;
            s1_last_q     <= s1_last_d;
            s1_en_q       <= s1_en_d;
            s1_at_max_q   <= s1_at_max_d;
            state_q       <= state_d;
            match_valid_q <= match_valid_d;
            match_q       <= match_d;
            match_count_q <= match_count_d;
        end
    end

endmodule

// File: tb/tb_pattern_matcher.sv
// Scoreboard bench for pattern_matcher: frames push expected verdicts, a monitor pops them on each strobe.
// The pattern memory is modelled here with a one-cycle registered read port.
module tb_pattern_matcher;

    typedef struct {
        logic        m;
        logic [31:0] cnt;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  tdata = 8'h00;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic [10:0] mem_addr;
    logic [29:0] mem_data;
    logic        match_valid;
    logic        match;
    logic [31:0] match_count;

    logic [29:0] mem [0:2047];
    logic [7:0]  frame_buf [0:3071];

    int          cyc = 0;
    int          tests_run = 0;
    int          tests_failed = 0;
    int          strobes = 0;
    logic [31:0] exp_count = 32'd0;
    exp_t        sb[$];
    exp_t        mon_e;

    pattern_matcher #(.ADDR_WIDTH(11), .COUNT_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .s_axis_tdata (tdata),
        .s_axis_tvalid(tvalid),
        .s_axis_tlast (tlast),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .match_valid  (match_valid),
        .match        (match),
        .match_count  (match_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_data <= mem[mem_addr];
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Every strobe must correspond to the oldest outstanding expected verdict.
    always @(negedge clk) begin
        if (!rst && match_valid) begin
            strobes++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("match", {31'd0, match}, {31'd0, mon_e.m});
                checkOutput("match_count", match_count, mon_e.cnt);
                checkOutput("latency_cycle", cyc, mon_e.cyc);
            end
        end
    end

    function automatic logic [29:0] make_entry(input logic [7:0] val, input logic [7:0] mask, input logic marker);
        return {13'h1555, marker, mask, val};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 2048; i++) mem[i] = 30'd0;
    endtask

    task automatic load_abc_pattern();
        clear_mem();
        mem[0] = make_entry(8'h00, 8'hFF, 1'b0);
        mem[1] = make_entry(8'h11, 8'hFF, 1'b0);
        mem[2] = make_entry(8'h22, 8'hFF, 1'b1);
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic last, input logic en);
        @(negedge clk);
        tdata  = d;
        tlast  = last;
        tvalid = 1'b1;
        enable = en;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            tvalid = 1'b0;
            tlast  = 1'b0;
        end
    endtask

    task automatic push_expect(input logic m);
        exp_t e;
        if (m) exp_count = exp_count + 32'd1;
        e.m   = m;
        e.cnt = exp_count;
        e.cyc = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic send_frame(input int len, input logic en_start, input int switch_at, input logic exp_m);
        for (int i = 0; i < len; i++) begin
            applyStimulus(frame_buf[i], (i == len - 1), (i < switch_at) ? en_start : !en_start);
        end
        push_expect(exp_m);
    endtask

    task automatic fill_abc_frame(input int len);
        for (int i = 0; i < len; i++) frame_buf[i] = 8'(i * 3 + 5);
        frame_buf[0] = 8'h00;
        frame_buf[1] = 8'h11;
        frame_buf[2] = 8'h22;
    endtask

    task automatic wait_drain();
        int budget = 20;
        while (sb.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput("scoreboard_drained", sb.size(), 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst    = 1'b1;
        tvalid = 1'b0;
        tlast  = 1'b0;
        exp_count = 32'd0;
        @(negedge clk);
        checkOutput("rst_mem_addr", {21'd0, mem_addr}, 32'd0);
        checkOutput("rst_match_valid", {31'd0, match_valid}, 32'd0);
        checkOutput("rst_match", {31'd0, match}, 32'd0);
        checkOutput("rst_match_count", match_count, 32'd0);
        rst = 1'b0;
        idle(4);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base_strobes;
        logic [31:0] base_count;

        load_abc_pattern();
        repeat (3) @(negedge clk);
        checkOutput("reset_mem_addr", {21'd0, mem_addr}, 32'd0);
        checkOutput("reset_match_valid", {31'd0, match_valid}, 32'd0);
        checkOutput("reset_match", {31'd0, match}, 32'd0);
        checkOutput("reset_match_count", match_count, 32'd0);
        rst = 1'b0;
        idle(2);

        // Test 1: matching 60-byte frame
        fill_abc_frame(60);
        send_frame(60, 1'b1, 60, 1'b1);
        idle(3);
        wait_drain();

        // Test 2: mismatch on byte 1, then masked-out bit
        fill_abc_frame(8);
        frame_buf[1] = 8'h13;
        send_frame(8, 1'b1, 8, 1'b0);
        idle(2);
        mem[1] = make_entry(8'h11, 8'hFD, 1'b0);
        send_frame(8, 1'b1, 8, 1'b1);
        idle(3);
        wait_drain();
        load_abc_pattern();

        // Test 3: end marker at entry 9, short vs full frame
        clear_mem();
        for (int i = 0; i < 10; i++) begin
            mem[i] = make_entry(8'(8'hA0 + i), 8'hFF, (i == 9));
            frame_buf[i] = 8'(8'hA0 + i);
        end
        send_frame(5, 1'b1, 5, 1'b0);
        idle(1);
        send_frame(10, 1'b1, 10, 1'b1);
        idle(3);
        wait_drain();

        // Test 4: 100 back-to-back frames alternating match/mismatch
        load_abc_pattern();
        base_strobes = strobes;
        base_count   = exp_count;
        for (int f = 0; f < 100; f++) begin
            frame_buf[0] = 8'h00;
            frame_buf[1] = 8'h11;
            frame_buf[2] = (f % 2 == 0) ? 8'h22 : 8'h23;
            frame_buf[3] = 8'h33;
            send_frame(4, 1'b1, 4, (f % 2 == 0));
        end
        idle(4);
        wait_drain();
        checkOutput("t4_strobes", strobes - base_strobes, 32'd100);
        checkOutput("t4_match_count", match_count, base_count + 32'd50);

        // Test 5: no end marker, 3000-byte frame saturates the address
        clear_mem();
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(8'(i), (i == 2999), 1'b1);
            if (i == 100)  checkOutput("t5_addr_100", {21'd0, mem_addr}, 32'd100);
            if (i == 2047) checkOutput("t5_addr_2047", {21'd0, mem_addr}, 32'd2047);
            if (i == 2500) checkOutput("t5_addr_sat", {21'd0, mem_addr}, 32'd2047);
        end
        push_expect(1'b0);
        idle(1);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("t5_next_addr", {21'd0, mem_addr}, 32'd0);
        applyStimulus(8'h00, 1'b1, 1'b1);
        push_expect(1'b0);
        idle(3);
        wait_drain();

        // Test 6: enable changes only take effect at frame start
        load_abc_pattern();
        fill_abc_frame(40);
        send_frame(40, 1'b1, 30, 1'b1);
        send_frame(40, 1'b0, 40, 1'b0);
        idle(3);
        wait_drain();
        send_frame(40, 1'b0, 1, 1'b0);
        idle(3);
        wait_drain();

        // Reset mid-frame drops the frame; next beat is offset 0
        for (int i = 0; i < 20; i++) applyStimulus(frame_buf[i], 1'b0, 1'b1);
        pulse_reset();
        send_frame(6, 1'b1, 6, 1'b1);
        idle(3);
        wait_drain();

        // Reset while a verdict is pending discards it
        for (int i = 0; i < 6; i++) applyStimulus(frame_buf[i], (i == 5), 1'b1);
        pulse_reset();
        send_frame(6, 1'b1, 6, 1'b1);
        idle(3);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
